sar_conversion_controller: RTL and testbench
============================================

# sar_conversion_controller

Digital front end and sequencer for the ideal SAR ADC model; the counterpart of the successive-approximation register on the same interface. It accepts a digital input sample over a valid/ready handshake, holds it, acts as the ideal comparator against the SAR's trial code, and drives `conduct_comparison` for exactly one conversion. It then captures the final code and presents it on a valid/ready result port. It sits between the stimulus/sample source and the SAR register in the ideal ADC top level.

## Interface
- `N_BITS`, 10, conversion resolution; must match the SAR register.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `sample_valid`  in  1  input sample offered.
- `sample_ready`  out  1  controller can accept a sample.
- `sample_code`  in  N_BITS  unsigned ideal input voltage in LSB units.
- `dac_code`  in  N_BITS  trial code from the SAR's `quantized_voltage`.
- `sar_eoc`  in  1  end of conversion from the SAR.
- `feedback_value`  out  1  comparator decision to the SAR.
- `conduct_comparison`  out  1  enables the SAR; high only during a conversion.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  consumer accepts the result.
- `result_data`  out  N_BITS  converted code.
- `eoc_error`  out  1  sticky protocol error. Tied 0 unless the macro is enabled.

## Operation
- States: IDLE, CONVERT, HOLD.
- IDLE:
  - `sample_ready`=1 and `conduct_comparison`=0.
  - On `sample_valid`&&`sample_ready`, `sample_code` is registered into `held_sample` and the state moves to CONVERT.
- CONVERT:
  - `conduct_comparison`=1 every cycle; `sample_ready`=0.
  - Combinational `feedback_value` = (`held_sample` >= `dac_code`). This is an unsigned N_BITS compare, with no pipelining.
  - On the cycle where the conversion ends (see Configuration), `result_data` <= {`dac_code`[N_BITS-1:1], `feedback_value`}. The SAR still shows bit 0 forced to 1 on that cycle, so the comparator decision is used for bit 0.
  - The state then moves to HOLD.
- HOLD:
  - `conduct_comparison`=0, `result_valid`=1, and `result_data` stays stable.
  - On `result_valid`&&`result_ready`, the state moves to IDLE.
- `conduct_comparison` is never high in two consecutive conversions without a low cycle between them. The low cycle lets the SAR clear its register, which guarantees that the MSB trial code is 100…0.
- `feedback_value` = 0 outside CONVERT.
- `held_sample` changes only on a sample handshake.

## Timing
- Reset values:
  - state IDLE
  - `sample_ready`=1
  - `conduct_comparison`=0, `feedback_value`=0
  - `result_valid`=0, `result_data`=0
  - `held_sample`=0, `eoc_error`=0
- A sample accepted at edge of cycle T gives:
  - `conduct_comparison` high for cycles T+1 … T+2·N_BITS (2·N_BITS cycles; two SAR cycles per bit);
  - `sar_eoc` expected in cycle T+2·N_BITS;
  - `result_valid` from cycle T+2·N_BITS+1.
- Minimum sample-to-sample period is 2·N_BITS+2 cycles with `result_ready` held high: one cycle each in HOLD and IDLE.
- Result backpressure: while in HOLD with `result_ready`=0, the controller holds `result_valid` and `result_data` and keeps `sample_ready`=0. No samples are dropped or overwritten.
- `sample_valid` outside IDLE is ignored, and the source must hold it.
- If `reset` is asserted mid-conversion, all outputs return to reset values immediately. `conduct_comparison` drops asynchronously and any partial result is discarded. The SAR shares `reset`, so both ends restart aligned.
- `sar_eoc` seen outside CONVERT is ignored, apart from the error check below.

## Configuration
- Macro: `SAR_CTRL_EOC_CHECK_EN`.
- When defined:
  - An internal counter counts CONVERT cycles from 0 to 2·N_BITS−1. The conversion ends when the count reaches 2·N_BITS−1, whatever `sar_eoc` does.
  - `eoc_error` sets and stays set until reset if either of these occurs:
    - `sar_eoc`=1 in CONVERT with count ≠ 2·N_BITS−1;
    - `sar_eoc`=0 at count 2·N_BITS−1.
  - `sar_eoc`=1 outside CONVERT also sets `eoc_error`.
- When undefined:
  - There is no counter.
  - The conversion ends on the first CONVERT cycle with `sar_eoc`=1.
  - `eoc_error` is tied 0.

## Test plan
All scenarios use N_BITS=10 with the SAR register attached.
- Sample 0x2A5, `result_ready`=1 → `conduct_comparison` high for exactly 20 cycles; `result_valid` 21 cycles after acceptance with `result_data`=0x2A5.
- Boundary samples 0x000, 0x3FF, 0x200, 0x1FF → `result_data` equals the input each time.
- Three back-to-back samples with `sample_valid` always high and `result_ready`=1 → results in order; accept period 22 cycles; `conduct_comparison` low ≥1 cycle between conversions.
- `result_ready`=0 for 7 cycles after `result_valid` → `result_data` stable, `sample_ready`=0 throughout, next sample accepted one cycle after the handshake.
- `reset` pulsed at conversion cycle 9 of sample 0x155 → outputs at reset values immediately, no `result_valid`; a following sample 0x0F0 converts to 0x0F0.
- With `SAR_CTRL_EOC_CHECK_EN`, force `sar_eoc`=1 at CONVERT cycle 5 → `eoc_error`=1 and sticky; conversion still ends at cycle 19. Without the macro, `eoc_error` is always 0.

Source files
------------

// File: rtl/sar_conversion_controller_if.sv
// Sample, SAR-feedback and result signals between the SAR conversion controller and its neighbours.
interface sar_conversion_controller_if #(
  parameter int unsigned N_BITS = 10
) ();

  logic              sample_valid;
  logic              sample_ready;
  logic [N_BITS-1:0] sample_code;
  logic [N_BITS-1:0] dac_code;
  logic              sar_eoc;
  logic              feedback_value;
  logic              conduct_comparison;
  logic              result_valid;
  logic              result_ready;
  logic [N_BITS-1:0] result_data;
  logic              eoc_error;

  modport slave (
    input  sample_valid, sample_code, dac_code, sar_eoc, result_ready,
    output sample_ready, feedback_value, conduct_comparison,
           result_valid, result_data, eoc_error
  );

  modport master (
    output sample_valid, sample_code, dac_code, sar_eoc, result_ready,
    input  sample_ready, feedback_value, conduct_comparison,
           result_valid, result_data, eoc_error
  );

endinterface

// File: rtl/sar_conversion_controller.sv
// Sequencer and ideal comparator for the SAR register: accept sample, convert, present result.
// Optional SAR_CTRL_EOC_CHECK_EN: fixed-length conversion with a sticky sar_eoc protocol error flag.
module sar_conversion_controller #(
  parameter int unsigned N_BITS = 10
) (
  input logic                       clk,
  input logic                       reset,
  sar_conversion_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    HOLD
  } state_t;

  state_t            state;
  logic [N_BITS-1:0] held_sample;
  logic              sample_ready_q;
  logic              conduct_q;
  logic              result_valid_q;
  logic [N_BITS-1:0] result_data_q;
  logic              feedback_c;
  logic              conv_done_c;

  // Ideal comparator, only live while the SAR is being driven.
  assign feedback_c = (state == CONVERT) && (held_sample >= bus.dac_code);

`ifdef SAR_CTRL_EOC_CHECK_EN
  localparam int unsigned CNT_W = $clog2(2 * N_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * N_BITS - 1);

  logic [CNT_W-1:0] conv_cnt;
  logic             eoc_error_q;

  assign conv_done_c = (state == CONVERT) && (conv_cnt == LAST_CNT);

  // Conversion length is owned locally; sar_eoc is only cross-checked against it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conv_cnt    <= '0;
      eoc_error_q <= 1'b0;
    end else begin
      if (state == CONVERT && !conv_done_c) begin
        conv_cnt <= conv_cnt + CNT_W'(1);
      end else begin
        conv_cnt <= '0;
      end
      if ((state == CONVERT && (bus.sar_eoc != conv_done_c)) ||
          (state != CONVERT && bus.sar_eoc)) begin
        eoc_error_q <= 1'b1;
      end
    end
  end

  assign bus.eoc_error = eoc_error_q;
`else
  assign conv_done_c   = (state == CONVERT) && bus.sar_eoc;
  assign bus.eoc_error = 1'b0;
`endif

  // Main sequencer; the final SAR cycle still shows bit 0 forced high, so the
  // comparator decision replaces it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      held_sample    <= '0;
      sample_ready_q <= 1'b1;
      conduct_q      <= 1'b0;
      result_valid_q <= 1'b0;
      result_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.sample_valid && sample_ready_q) begin
            held_sample    <= bus.sample_code;
            sample_ready_q <= 1'b0;
            conduct_q      <= 1'b1;
            state          <= CONVERT;
          end
        end
        CONVERT: begin
          if (conv_done_c) begin
            result_data_q  <= {bus.dac_code[N_BITS-1:1], feedback_c};
            conduct_q      <= 1'b0;
            result_valid_q <= 1'b1;
            state          <= HOLD;
          end
        end
        HOLD: begin
          if (bus.result_ready) begin
            result_valid_q <= 1'b0;
            sample_ready_q <= 1'b1;
            state          <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.sample_ready       = sample_ready_q;
  assign bus.conduct_comparison = conduct_q;
  assign bus.result_valid       = result_valid_q;
  assign bus.result_data        = result_data_q;
  assign bus.feedback_value     = feedback_c;

endmodule

// File: tb/tb_sar_conversion_controller.sv
// Bench for sar_conversion_controller with a behavioural SAR register attached.
module tb_sar_conversion_controller;

  localparam int NB   = 10;
  localparam int CONV = 2 * NB;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  sar_conversion_controller_if #(.N_BITS(NB)) bus ();

  sar_conversion_controller #(.N_BITS(NB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural SAR register: two cycles per bit, MSB first, cleared while idle.
  int              sar_cnt;
  logic [NB-1:0]   sar_reg;
  logic [NB-1:0]   dac_c;
  int              bit_idx;
  logic            inject_en = 1'b0;

  always_comb begin
    bit_idx = NB - 1 - sar_cnt / 2;
    dac_c   = sar_reg;
    if (bus.conduct_comparison && sar_cnt < CONV) dac_c[bit_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sar_cnt <= 0;
      sar_reg <= '0;
    end else if (!bus.conduct_comparison) begin
      sar_cnt <= 0;
      sar_reg <= '0;
    end else begin
      if (sar_cnt[0] && sar_cnt < CONV) sar_reg[bit_idx] <= bus.feedback_value;
      sar_cnt <= sar_cnt + 1;
    end
  end

  assign bus.dac_code = dac_c;
  assign bus.sar_eoc  = bus.conduct_comparison &&
                        ((sar_cnt == CONV - 1) || (inject_en && sar_cnt == 5));

  // Reference model: age counts cycles since acceptance, hold means a result is offered.
  int            m_age;
  logic          m_hold;
  logic [NB-1:0] m_code;
  logic          m_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_age  <= -1;
      m_hold <= 1'b0;
      m_code <= '0;
      m_err  <= 1'b0;
    end else begin
      if (inject_en && m_age == 6) m_err <= 1'b1;
      if (m_hold) begin
        if (bus.result_ready) m_hold <= 1'b0;
      end else if (m_age < 0) begin
        if (bus.sample_valid) begin
          m_age  <= 1;
          m_code <= bus.sample_code;
        end
      end else if (m_age == CONV) begin
        m_age  <= -1;
        m_hold <= 1'b1;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  // Per-cycle compare against the model.
  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("sample_ready", 32'(bus.sample_ready), 32'(m_age < 0 && !m_hold));
      chk("conduct", 32'(bus.conduct_comparison), 32'(m_age > 0));
      chk("result_valid", 32'(bus.result_valid), 32'(m_hold));
      if (m_hold) chk("result_data", 32'(bus.result_data), 32'(m_code));
      chk("feedback", 32'(bus.feedback_value), 32'((m_age > 0) && (m_code >= dac_c)));
`ifdef SAR_CTRL_EOC_CHECK_EN
      chk("eoc_error", 32'(bus.eoc_error), 32'(m_err));
`else
      chk("eoc_error", 32'(bus.eoc_error), 32'd0);
`endif
    end
  end

  // Event monitor: acceptance cycles, conduct run lengths, result arrivals.
  int            cyc = 0;
  int            acc_q[$];
  int            rhs_q[$];
  int            run_q[$];
  int            rv_q[$];
  logic [NB-1:0] res_q[$];
  int            run = 0;
  logic          rv_prev = 1'b0;

  always @(posedge clk) begin
    if (!reset && bus.sample_valid && bus.sample_ready) acc_q.push_back(cyc);
    if (!reset && bus.result_valid && bus.result_ready) rhs_q.push_back(cyc);
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (reset) begin
      run     = 0;
      rv_prev = 1'b0;
    end else begin
      if (bus.conduct_comparison) run++;
      else if (run > 0) begin
        run_q.push_back(run);
        run = 0;
      end
      if (bus.result_valid && !rv_prev) begin
        rv_q.push_back(cyc);
        res_q.push_back(bus.result_data);
      end
      rv_prev = bus.result_valid;
    end
  end

  task automatic wait_accept(input int n_before);
    int k = 0;
    while (acc_q.size() <= n_before && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (acc_q.size() <= n_before) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_results(input int n_target);
    int k = 0;
    while (res_q.size() < n_target && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (res_q.size() < n_target) chk("result_timeout", 32'd0, 32'd1);
  endtask

  // One full transaction; stall_cycles holds result_ready low after result_valid.
  task automatic send(input logic [NB-1:0] code, input int stall_cycles);
    int na = acc_q.size();
    int nr = res_q.size();
    bus.result_ready = (stall_cycles == 0);
    bus.sample_code  = code;
    bus.sample_valid = 1'b1;
    wait_accept(na);
    bus.sample_valid = 1'b0;
    wait_results(nr + 1);
    repeat (stall_cycles) begin
      @(posedge clk); #1;
    end
    bus.result_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [NB-1:0] bnd[4] = '{10'h000, 10'h3FF, 10'h200, 10'h1FF};
  logic [NB-1:0] b2b[3] = '{10'h123, 10'h3C3, 10'h05A};

  initial begin
    int b;
    int nrv;
    int k;
    bus.sample_valid = 1'b0;
    bus.sample_code  = '0;
    bus.result_ready = 1'b1;
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("rst_sample_ready", 32'(bus.sample_ready), 32'd1);
    chk("rst_conduct", 32'(bus.conduct_comparison), 32'd0);
    chk("rst_feedback", 32'(bus.feedback_value), 32'd0);
    chk("rst_result_valid", 32'(bus.result_valid), 32'd0);
    chk("rst_result_data", 32'(bus.result_data), 32'd0);
    chk("rst_eoc_error", 32'(bus.eoc_error), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cmp_en = 1'b1;

    // Single conversion: length and latency pinned by literals.
    send(10'h2A5, 0);
    chk("t1_result", 32'(res_q[$]), 32'h2A5);
    chk("t1_conduct_len", 32'(run_q[$]), 32'd20);
    chk("t1_latency", 32'(rv_q[$] - acc_q[$]), 32'd21);

    foreach (bnd[i]) begin
      send(bnd[i], 0);
      chk("bnd_result", 32'(res_q[$]), 32'(bnd[i]));
    end

    // Back-to-back with sample_valid held high throughout.
    b = acc_q.size();
    bus.result_ready = 1'b1;
    bus.sample_valid = 1'b1;
    foreach (b2b[i]) begin
      bus.sample_code = b2b[i];
      wait_accept(b + i);
    end
    bus.sample_valid = 1'b0;
    wait_results(res_q.size() + ((res_q.size() < b + 3) ? (b + 3 - res_q.size()) : 0));
    repeat (3) @(posedge clk);
    #1;
    foreach (b2b[i]) chk("b2b_result", 32'(res_q[b + i]), 32'(b2b[i]));
    chk("b2b_period0", 32'(acc_q[b + 1] - acc_q[b]), 32'd22);
    chk("b2b_period1", 32'(acc_q[b + 2] - acc_q[b + 1]), 32'd22);
    for (int i = 0; i < 3; i++) chk("b2b_conduct_len", 32'(run_q[run_q.size() - 1 - i]), 32'd20);

    // Backpressure for 7 cycles, next sample already waiting.
    b = acc_q.size();
    bus.result_ready = 1'b0;
    bus.sample_code  = 10'h0AA;
    bus.sample_valid = 1'b1;
    wait_accept(b);
    bus.sample_valid = 1'b0;
    wait_results(res_q.size() + 1);
    bus.sample_code  = 10'h111;
    bus.sample_valid = 1'b1;
    repeat (7) begin
      chk("bp_data_stable", 32'(bus.result_data), 32'h0AA);
      chk("bp_sample_ready", 32'(bus.sample_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.result_ready = 1'b1;
    wait_accept(b + 1);
    bus.sample_valid = 1'b0;
    chk("bp_accept_after_hs", 32'(acc_q[b + 1] - rhs_q[$]), 32'd1);
    wait_results(res_q.size() + 1);
    chk("bp_next_result", 32'(res_q[$]), 32'h111);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-conversion discards the partial result.
    nrv = rv_q.size();
    bus.sample_code  = 10'h155;
    bus.sample_valid = 1'b1;
    wait_accept(acc_q.size());
    bus.sample_valid = 1'b0;
    k = 0;
    while (k < 9) begin
      @(negedge clk);
      if (bus.conduct_comparison) k++;
    end
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_conduct", 32'(bus.conduct_comparison), 32'd0);
    chk("mid_rst_ready", 32'(bus.sample_ready), 32'd1);
    chk("mid_rst_valid", 32'(bus.result_valid), 32'd0);
    chk("mid_rst_data", 32'(bus.result_data), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("mid_rst_no_result", 32'(rv_q.size()), 32'(nrv));
    send(10'h0F0, 0);
    chk("post_rst_result", 32'(res_q[$]), 32'h0F0);

`ifdef SAR_CTRL_EOC_CHECK_EN
    inject_en = 1'b1;
    send(10'h2F0, 0);
    inject_en = 1'b0;
    chk("inj_result", 32'(res_q[$]), 32'h2F0);
    chk("inj_conduct_len", 32'(run_q[$]), 32'd20);
    chk("inj_latency", 32'(rv_q[$] - acc_q[$]), 32'd21);
    repeat (5) @(posedge clk);
    #1;
    chk("inj_eoc_sticky", 32'(bus.eoc_error), 32'd1);
`else
    chk("eoc_error_tied", 32'(bus.eoc_error), 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
